// File: rtl/lamp_pkg.sv
// -----------------------------------------------------------------------------
// lamp_pkg
//   Shared encodings for the 3-bit one-hot lamp bus and the tracked phase.
//   Imported by the lamp controller and by the receive-side monitor so the two
//   ends of the bus cannot drift apart.
// -----------------------------------------------------------------------------
package lamp_pkg;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] GREEN  = 3'b010;
  localparam logic [2:0] YELLOW = 3'b001;

  typedef enum logic [1:0] {
    PH_SYNC   = 2'd0,
    PH_GREEN  = 2'd1,
    PH_YELLOW = 2'd2,
    PH_RED    = 2'd3
  } phase_e;

  // Only the three defined colours count as one-hot on this bus.
  function automatic logic is_colour(input logic [2:0] l);
    return (l == RED) || (l == GREEN) || (l == YELLOW);
  endfunction

  function automatic phase_e colour_to_phase(input logic [2:0] l);
    case (l)
      GREEN:   return PH_GREEN;
      YELLOW:  return PH_YELLOW;
      RED:     return PH_RED;
      default: return PH_SYNC;
    endcase
  endfunction

  // Legal successor in the G -> Y -> R -> G ring.
  function automatic phase_e next_phase(input phase_e p);
    case (p)
      PH_GREEN:  return PH_YELLOW;
      PH_YELLOW: return PH_RED;
      PH_RED:    return PH_GREEN;
      default:   return PH_SYNC;
    endcase
  endfunction

endpackage

// File: rtl/lamp_dwell_counter.sv
// -----------------------------------------------------------------------------
// lamp_dwell_counter
//   Counts consecutive samples of the current colour, saturating at
//   MAX_DWELL+1 so an over-long hold is reported only once.
// Ports:
//   clock, reset_n : clock, asynchronous active-low reset
//   restart        : load 1 (first sample of a newly adopted colour)
//   inc            : count one more sample, saturating
//   clr            : load 0 (SYNC / disabled); highest priority
//   count          : current dwell
//   short_o        : count < MIN_DWELL
//   over_o         : count + 1 would exceed MAX_DWELL
// -----------------------------------------------------------------------------
module lamp_dwell_counter #(
  parameter int MIN_DWELL = 1,
  parameter int MAX_DWELL = 1,
  localparam int W = $clog2(MAX_DWELL + 2)
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         restart,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         short_o,
  output logic         over_o
);

  localparam logic [W-1:0] MIN_C = W'(MIN_DWELL);
  localparam logic [W-1:0] MAX_C = W'(MAX_DWELL);
  localparam logic [W-1:0] SAT_C = W'(MAX_DWELL + 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (restart) begin
      count_d = W'(1);
    end else if (inc && (count_q != SAT_C)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign short_o = (count_q < MIN_C);
  assign over_o  = (count_q >= MAX_C);

endmodule

// File: rtl/lamp_sequence_monitor.sv
// -----------------------------------------------------------------------------
// lamp_sequence_monitor
//   Passive receive-side checker for the one-hot lamp bus. Tracks the legal
//   GREEN -> YELLOW -> RED -> GREEN sequence, raises sticky encoding, ordering
//   and dwell-time flags, and counts complete cycles.
// Ports:
//   clock, reset_n : clock, asynchronous active-low reset
//   light          : observed lamp bus (RED=100, GREEN=010, YELLOW=001)
//   enable         : 1 = checking; 0 = force SYNC, hold flags (clear_err is
//                    ignored too) and cycle_count
//   clear_err      : synchronous clear of sticky flags; a new error at the
//                    same edge wins
//   phase          : 0=SYNC, 1=GREEN, 2=YELLOW, 3=RED
//   encode_err     : sticky, sample not one-hot
//   seq_err        : sticky, out-of-order colour change
//   dwell_err      : sticky, colour held fewer than MIN or more than MAX samples
//   cycle_done     : one-clock pulse on a clean G-Y-R-G completion
//   cycle_count    : completed cycles, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module lamp_sequence_monitor
  import lamp_pkg::*;
#(
  parameter int MIN_DWELL = 1,
  parameter int MAX_DWELL = 1,
  parameter int CNT_W     = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [2:0]       light,
  input  logic             enable,
  input  logic             clear_err,
  output logic [1:0]       phase,
  output logic             encode_err,
  output logic             seq_err,
  output logic             dwell_err,
  output logic             cycle_done,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int           DW_W  = $clog2(MAX_DWELL + 2);
  localparam logic [DW_W-1:0] SAT_C = DW_W'(MAX_DWELL + 1);

  phase_e           phase_q, phase_d;
  logic             armed_q, armed_d;
  logic             encode_err_q, encode_err_d;
  logic             seq_err_q, seq_err_d;
  logic             dwell_err_q, dwell_err_d;
  logic             cycle_done_q, cycle_done_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;

  logic             dw_restart, dw_inc, dw_clr;
  logic [DW_W-1:0]  dwell;
  logic             dw_short, dw_over;
  logic             new_enc, new_seq, new_dwell;
  phase_e           obs;

  lamp_dwell_counter #(
    .MIN_DWELL (MIN_DWELL),
    .MAX_DWELL (MAX_DWELL)
  ) u_dwell (
    .clock   (clock),
    .reset_n (reset_n),
    .restart (dw_restart),
    .inc     (dw_inc),
    .clr     (dw_clr),
    .count   (dwell),
    .short_o (dw_short),
    .over_o  (dw_over)
  );

  always_comb begin
    phase_d       = phase_q;
    armed_d       = armed_q;
    encode_err_d  = encode_err_q;
    seq_err_d     = seq_err_q;
    dwell_err_d   = dwell_err_q;
    cycle_done_d  = 1'b0;
    cycle_count_d = cycle_count_q;
    dw_restart    = 1'b0;
    dw_inc        = 1'b0;
    dw_clr        = 1'b0;
    new_enc       = 1'b0;
    new_seq       = 1'b0;
    new_dwell     = 1'b0;
    obs           = colour_to_phase(light);

    if (!enable) begin
      phase_d = PH_SYNC;
      armed_d = 1'b0;
      dw_clr  = 1'b1;
    end else begin
      if (!is_colour(light)) begin
        new_enc = 1'b1;
        phase_d = PH_SYNC;
        dw_clr  = 1'b1;
      end else if (phase_q == PH_SYNC) begin
        // Adopt without an order check; only a GREEN start can complete a cycle.
        phase_d    = obs;
        dw_restart = 1'b1;
        armed_d    = (obs == PH_GREEN);
      end else if (obs == phase_q) begin
        dw_inc = 1'b1;
        // Report only the step that first crosses MAX; the saturated state is quiet.
        if (dw_over && (dwell != SAT_C)) new_dwell = 1'b1;
      end else if (obs == next_phase(phase_q)) begin
        if (dw_short) new_dwell = 1'b1;
        phase_d    = obs;
        dw_restart = 1'b1;
        if (obs == PH_GREEN) begin
          if (armed_q && !new_dwell) begin
            cycle_done_d  = 1'b1;
            cycle_count_d = cycle_count_q + CNT_W'(1);
          end
          armed_d = 1'b1;
        end
      end else begin
        // Skip or reverse: resync straight onto the observed colour.
        new_seq    = 1'b1;
        phase_d    = obs;
        dw_restart = 1'b1;
      end

      // An error anywhere in the cycle disarms, overriding a fresh GREEN entry.
      if (new_enc || new_seq || new_dwell) armed_d = 1'b0;

      encode_err_d = (encode_err_q && !clear_err) || new_enc;
      seq_err_d    = (seq_err_q    && !clear_err) || new_seq;
      dwell_err_d  = (dwell_err_q  && !clear_err) || new_dwell;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase_q       <= PH_SYNC;
      armed_q       <= 1'b0;
      encode_err_q  <= 1'b0;
      seq_err_q     <= 1'b0;
      dwell_err_q   <= 1'b0;
      cycle_done_q  <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      phase_q       <= phase_d;
      armed_q       <= armed_d;
      encode_err_q  <= encode_err_d;
      seq_err_q     <= seq_err_d;
      dwell_err_q   <= dwell_err_d;
      cycle_done_q  <= cycle_done_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign phase       = phase_q;
  assign encode_err  = encode_err_q;
  assign seq_err     = seq_err_q;
  assign dwell_err   = dwell_err_q;
  assign cycle_done  = cycle_done_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_lamp_sequence_monitor.sv
module tb_lamp_sequence_monitor;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] G = 3'b010;
  localparam logic [2:0] Y = 3'b001;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [2:0] light;
  logic       enable;
  logic       clear_err;

  logic [1:0] a_phase, b_phase;
  logic       a_enc, a_seq, a_dw, a_done;
  logic       b_enc, b_seq, b_dw, b_done;
  logic [1:0] a_count;
  logic [3:0] b_count;

  int n_checks = 0;
  int n_fail   = 0;
  bit running  = 1'b0;

  always #5 clock = ~clock;

  // Instance A: one sample per colour, 2-bit counter for wrap checks.
  lamp_sequence_monitor #(.MIN_DWELL(1), .MAX_DWELL(1), .CNT_W(2)) dut_a (
    .clock(clock), .reset_n(reset_n), .light(light), .enable(enable),
    .clear_err(clear_err), .phase(a_phase), .encode_err(a_enc), .seq_err(a_seq),
    .dwell_err(a_dw), .cycle_done(a_done), .cycle_count(a_count));

  // Instance B: exactly two samples per colour allowed.
  lamp_sequence_monitor #(.MIN_DWELL(2), .MAX_DWELL(2), .CNT_W(4)) dut_b (
    .clock(clock), .reset_n(reset_n), .light(light), .enable(enable),
    .clear_err(clear_err), .phase(b_phase), .encode_err(b_enc), .seq_err(b_seq),
    .dwell_err(b_dw), .cycle_done(b_done), .cycle_count(b_count));

  // ---------------- behavioural model ----------------
  // Colours are numbered 1=G, 2=Y, 3=R; the legal successor of c is c%3+1.
  typedef struct packed {
    int ph;
    int dwell;
    bit armed;
    bit enc;
    bit seq;
    bit dw;
    bit done;
    int cnt;
  } mstate_t;

  mstate_t ma, mb;

  function automatic int col_of(input logic [2:0] l);
    if (l == G) return 1;
    if (l == Y) return 2;
    if (l == R) return 3;
    return 0;
  endfunction

  function automatic logic [2:0] idx2col(input int c);
    if (c == 1) return G;
    if (c == 2) return Y;
    return R;
  endfunction

  function automatic mstate_t mstep(input mstate_t s, input logic [2:0] l, input bit en,
                                    input bit clr, input int mn, input int mx, input int cw);
    mstate_t m;
    int c;
    bit e_enc, e_seq, e_dw;
    m = s;
    m.done = 1'b0;
    if (!en) begin
      m.ph = 0; m.dwell = 0; m.armed = 1'b0;
      return m;
    end
    c = col_of(l);
    e_enc = 1'b0; e_seq = 1'b0; e_dw = 1'b0;
    if (c == 0) begin
      e_enc = 1'b1; m.ph = 0; m.dwell = 0;
    end else if (s.ph == 0) begin
      m.ph = c; m.dwell = 1; m.armed = (c == 1);
    end else if (c == s.ph) begin
      e_dw = (s.dwell + 1 > mx) && (s.dwell <= mx);
      m.dwell = (s.dwell + 1 > mx + 1) ? mx + 1 : s.dwell + 1;
    end else if (c == s.ph % 3 + 1) begin
      e_dw = (s.dwell < mn);
      if (c == 1) begin
        if (s.armed && !e_dw) begin
          m.done = 1'b1;
          m.cnt  = (s.cnt + 1) % (1 << cw);
        end
        m.armed = 1'b1;
      end
      m.ph = c; m.dwell = 1;
    end else begin
      e_seq = 1'b1; m.ph = c; m.dwell = 1;
    end
    if (e_enc || e_seq || e_dw) m.armed = 1'b0;
    m.enc = (s.enc && !clr) || e_enc;
    m.seq = (s.seq && !clr) || e_seq;
    m.dw  = (s.dw  && !clr) || e_dw;
    return m;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ma <= '0;
      mb <= '0;
    end else begin
      ma <= mstep(ma, light, enable, clear_err, 1, 1, 2);
      mb <= mstep(mb, light, enable, clear_err, 2, 2, 4);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    if (running) begin
      chk("a_phase", int'(a_phase), ma.ph);
      chk("a_flags", int'({a_enc, a_seq, a_dw}), int'({ma.enc, ma.seq, ma.dw}));
      chk("a_done",  int'(a_done),  int'(ma.done));
      chk("a_count", int'(a_count), ma.cnt);
      chk("b_phase", int'(b_phase), mb.ph);
      chk("b_flags", int'({b_enc, b_seq, b_dw}), int'({mb.enc, mb.seq, mb.dw}));
      chk("b_done",  int'(b_done),  int'(mb.done));
      chk("b_count", int'(b_count), mb.cnt);
    end
  end

  // Apply one sample; returns 1 time unit after the edge that captured it.
  task automatic drv(input logic [2:0] l, input logic e, input logic c);
    light = l; enable = e; clear_err = c;
    @(posedge clock);
    #1;
  endtask

  task automatic mid_reset();
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_a_phase", int'(a_phase), 0);
    chk("async_rst_a_count", int'(a_count), 0);
    chk("async_rst_a_flags", int'({a_enc, a_seq, a_dw, a_done}), 0);
    chk("async_rst_b_count", int'(b_count), 0);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    int cur;
    int r;
    logic [2:0] l;
    reset_n = 1'b0; light = 3'b000; enable = 1'b0; clear_err = 1'b0;
    running = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_phase", int'(a_phase), 0);
    chk("rst_count", int'(a_count), 0);
    chk("rst_flags", int'({a_enc, a_seq, a_dw, a_done}), 0);
    #1 reset_n = 1'b1;

    // Clean G,Y,R,G
    drv(G, 1, 0); chk("t1_phase_g", int'(a_phase), 1);
    drv(Y, 1, 0); chk("t1_done_y", int'(a_done), 0);
    drv(R, 1, 0);
    drv(G, 1, 0);
    chk("t1_done", int'(a_done), 1);
    chk("t1_count", int'(a_count), 1);
    chk("t1_model_count", ma.cnt, 1);
    chk("t1_flags", int'({a_enc, a_seq, a_dw}), 0);
    drv(Y, 1, 0); chk("t1_pulse_end", int'(a_done), 0);

    // Disable forces SYNC, holds count
    drv(Y, 0, 0);
    chk("dis_phase", int'(a_phase), 0);
    chk("dis_count", int'(a_count), 1);

    // Skip G->R
    drv(G, 1, 0);
    drv(R, 1, 0);
    chk("t2_seq", int'(a_seq), 1);
    chk("t2_phase", int'(a_phase), 3);
    drv(G, 1, 0); chk("t2_no_done", int'(a_done), 0);
    drv(Y, 1, 0); drv(R, 1, 0);
    drv(G, 1, 0);
    chk("t2_done", int'(a_done), 1);
    chk("t2_count", int'(a_count), 2);

    // Clear with a legal sample
    drv(Y, 1, 1);
    chk("t5_clear", int'({a_enc, a_seq, a_dw}), 0);

    // Bad encoding, then resync on YELLOW without an order error
    drv(3'b011, 1, 0);
    chk("t3_enc", int'(a_enc), 1);
    chk("t3_phase", int'(a_phase), 0);
    drv(Y, 1, 0);
    chk("t3_phase_y", int'(a_phase), 2);
    chk("t3_seq", int'(a_seq), 0);

    // Clear together with an illegal change: set wins
    drv(G, 1, 1);
    chk("t5_set_wins", int'(a_seq), 1);
    chk("t5_enc_cleared", int'(a_enc), 0);

    // Wrap of the 2-bit counter: 2 -> 3,0,1,2
    drv(G, 0, 0);
    drv(G, 1, 0);
    for (int k = 0; k < 4; k++) begin
      drv(Y, 1, 0); drv(R, 1, 0); drv(G, 1, 0);
      chk("t6_wrap_count", int'(a_count), (3 + k) % 4);
    end

    // Asynchronous reset between edges
    drv(Y, 1, 0);
    mid_reset();

    // Dwell limits on instance B (MIN=MAX=2)
    drv(G, 1, 0);
    drv(G, 1, 0); chk("t4_b_dw_2nd", int'(b_dw), 0);
    drv(G, 1, 0); chk("t4_b_dw_3rd", int'(b_dw), 1);
    drv(G, 1, 1); chk("t4_b_saturated_clear", int'(b_dw), 0);
    drv(G, 0, 0);
    drv(G, 1, 0);
    drv(Y, 1, 0);
    chk("t4_b_short", int'(b_dw), 1);
    chk("t4_b_phase", int'(b_phase), 2);

    // Randomized run
    cur = 2;
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 55)      cur = cur % 3 + 1;
      else if (r < 88 && r >= 75) cur = int'($urandom_range(1, 3));
      l = idx2col(cur);
      if (r >= 88) l = 3'($urandom_range(0, 7));
      drv(l, ($urandom_range(0, 99) >= 3), ($urandom_range(0, 99) < 5));
      if ($urandom_range(0, 999) == 0) mid_reset();
    end

    @(posedge clock);
    #1;
    running = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
